// File: rtl/stack_arbiter.sv
// stack_arbiter: operand stack RAM plus stack pointer, shared by two 4-phase
// req/ack requesters (port 0 = operand path, port 1 = CALL/RET return path).
// Contending requests are resolved round-robin. Reports full/empty, sp and
// sticky overflow/underflow/req_err flags.
// Optional feature: define STACK_TOS_EN to add a registered top-of-stack output.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no transaction; sample requests, arbitrate, latch grant/op/data
// ACCESS | perform the latched push/pop on the RAM and sp, raise ack
// ACK    | hold ack/rdata until the granted request drops
module stack_arbiter #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_push,
    input  logic              r0_pop,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_push,
    input  logic              r1_pop,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_rdata,
    input  logic              err_clr,
    output logic [AW:0]       sp,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow,
    output logic              req_err,
    output logic              busy
`ifdef STACK_TOS_EN
    ,
    output logic [DATA_W-1:0] tos
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t            state;
    logic              grant;
    logic              last_grant;
    logic              op_push;
    logic              op_pop;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              req0;
    logic              req1;
    logic              gnt_sel;
    logic              gnt_req;
    logic [AW-1:0]     top_idx;
    logic              do_write;
    logic [DATA_W-1:0] rd_val;
`ifdef STACK_TOS_EN
    logic [AW-1:0]     below_idx;
    assign below_idx = AW'(sp - 2'd2);
`endif

    assign req0     = r0_push | r0_pop;
    assign req1     = r1_push | r1_pop;
    // With both requesting, the port that did not win last time goes next.
    assign gnt_sel  = (req0 && req1) ? ~last_grant : req1;
    assign gnt_req  = grant ? req1 : req0;
    assign full     = (sp == (AW+1)'(DEPTH));
    assign empty    = (sp == '0);
    assign busy     = (state != IDLE);
    assign top_idx  = AW'(sp - 1'b1);
    assign do_write = (state == ACCESS) && op_push && !op_pop && !full;

    // Pop data: top entry for a legal pop, zero for every other case.
    always_comb begin
        rd_val = '0;
        if (op_pop && !op_push && !empty)
            rd_val = mem[top_idx];
    end

    // Stack storage; deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_write)
            mem[sp[AW-1:0]] <= wdata_q;
    end

    // Arbitration/handshake FSM with stack pointer and sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            op_push    <= 1'b0;
            op_pop     <= 1'b0;
            wdata_q    <= '0;
            sp         <= '0;
            r0_ack     <= 1'b0;
            r1_ack     <= 1'b0;
            r0_rdata   <= '0;
            r1_rdata   <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            req_err    <= 1'b0;
`ifdef STACK_TOS_EN
            tos        <= '0;
`endif
        end else begin
            // Clear first so a flag set later in this cycle takes priority.
            if (err_clr) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
                req_err   <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant   <= gnt_sel;
                        op_push <= gnt_sel ? r1_push : r0_push;
                        op_pop  <= gnt_sel ? r1_pop : r0_pop;
                        wdata_q <= gnt_sel ? r1_wdata : r0_wdata;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (op_push && op_pop) begin
                        req_err <= 1'b1;
                    end else if (op_push) begin
                        if (full) begin
                            overflow <= 1'b1;
                        end else begin
                            sp <= sp + 1'b1;
`ifdef STACK_TOS_EN
                            tos <= wdata_q;
`endif
                        end
                    end else if (op_pop) begin
                        if (empty) begin
                            underflow <= 1'b1;
                        end else begin
                            sp <= sp - 1'b1;
`ifdef STACK_TOS_EN
                            tos <= (sp == (AW+1)'(1)) ? '0 : mem[below_idx];
`endif
                        end
                    end
                    if (grant) begin
                        r1_rdata <= rd_val;
                        r1_ack   <= 1'b1;
                    end else begin
                        r0_rdata <= rd_val;
                        r0_ack   <= 1'b1;
                    end
                    state <= ACK;
                end
                ACK: begin
                    if (!gnt_req) begin
                        r0_ack     <= 1'b0;
                        r1_ack     <= 1'b0;
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
